// File: rtl/mac_acc_cfu.sv
// Packed int8 multiply-accumulate unit: a register stage for the four lane
// products, followed by an accumulator, with read, read-and-clear and count commands.
module mac_acc_cfu #(
    parameter int BYTE_SIZE  = 8,
    parameter int INT32_SIZE = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            cmd,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [INT32_SIZE-1:0] inp0,
    input  logic [INT32_SIZE-1:0] inp1,
    output logic [INT32_SIZE-1:0] ret,
    output logic                  output_buffer_valid
);

    // A lane product is (int8 + int16 offset) * int8, which fits in 25 bits.
    // One spare bit is kept so the product is 26 bits wide.
    localparam int PROD_W = BYTE_SIZE + 18;

    localparam logic [6:0] CMD_CLEAR      = 7'd0;
    localparam logic [6:0] CMD_SET_OFFSET = 7'd1;
    localparam logic [6:0] CMD_MAC4       = 7'd2;
    localparam logic [6:0] CMD_READ       = 7'd3;
    localparam logic [6:0] CMD_READ_CLR   = 7'd4;
    localparam logic [6:0] CMD_READ_CNT   = 7'd5;

    logic signed [INT32_SIZE-1:0] acc;
    logic signed [15:0]           input_offset;
    logic [15:0]                  mac_count;
    logic                         s1_valid;
    logic signed [PROD_W-1:0]     p_q   [4];
    logic signed [PROD_W-1:0]     p_new [4];
    logic signed [INT32_SIZE-1:0] p_sum;
    logic                         is_read;
    logic                         accept;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic signed [BYTE_SIZE-1:0] act;
        logic signed [BYTE_SIZE-1:0] flt;
        logic signed [PROD_W-1:0]    act_off;
        assign act     = inp0[i*BYTE_SIZE +: BYTE_SIZE];
        assign flt     = inp1[i*BYTE_SIZE +: BYTE_SIZE];
        assign act_off = PROD_W'(act) + PROD_W'(input_offset);
        assign p_new[i] = act_off * PROD_W'(flt);
    end

    assign p_sum = INT32_SIZE'(p_q[0]) + INT32_SIZE'(p_q[1])
                 + INT32_SIZE'(p_q[2]) + INT32_SIZE'(p_q[3]);

    // Reads stall while a product is still in stage 1, so they always see a settled acc.
    assign is_read   = (cmd == CMD_READ) || (cmd == CMD_READ_CLR) || (cmd == CMD_READ_CNT);
    assign cmd_ready = !(is_read && s1_valid);
    assign accept    = cmd_valid && cmd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc                 <= '0;
            input_offset        <= '0;
            mac_count           <= '0;
            s1_valid            <= 1'b0;
            ret                 <= '0;
            output_buffer_valid <= 1'b0;
            for (int i = 0; i < 4; i++) p_q[i] <= '0;
        end else begin
            output_buffer_valid <= 1'b0;
            if (s1_valid) begin
                acc      <= acc + p_sum;
                s1_valid <= 1'b0;
            end
            // Command actions come after the drain so that clear wins over it.
            if (accept) begin
                case (cmd)
                    CMD_CLEAR: begin
                        acc       <= '0;
                        mac_count <= '0;
                        s1_valid  <= 1'b0;
                        ret       <= '0;
                    end
                    CMD_SET_OFFSET: input_offset <= inp1[15:0];
                    CMD_MAC4: begin
                        for (int i = 0; i < 4; i++) p_q[i] <= p_new[i];
                        s1_valid  <= 1'b1;
                        mac_count <= mac_count + 16'd1;
                    end
                    CMD_READ: begin
                        ret                 <= acc;
                        output_buffer_valid <= 1'b1;
                    end
                    CMD_READ_CLR: begin
                        ret                 <= acc;
                        output_buffer_valid <= 1'b1;
                        acc                 <= '0;
                    end
                    CMD_READ_CNT: begin
                        ret                 <= INT32_SIZE'(mac_count);
                        output_buffer_valid <= 1'b1;
                    end
                    default: ret <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mac_acc_cfu.sv
// Bench for mac_acc_cfu: directed command sequences feeding an expected-result
// queue that a monitor drains on each output_buffer_valid pulse.
module tb_mac_acc_cfu;

    logic        clk;
    logic        rst_n;
    logic [6:0]  cmd;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] inp0;
    logic [31:0] inp1;
    logic [31:0] ret;
    logic        output_buffer_valid;

    logic [31:0] exp_q[$];
    int          n_checks;
    int          n_fail;
    int          last_stalls;

    mac_acc_cfu #(.BYTE_SIZE(8), .INT32_SIZE(32)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .cmd                 (cmd),
        .cmd_valid           (cmd_valid),
        .cmd_ready           (cmd_ready),
        .inp0                (inp0),
        .inp1                (inp1),
        .ret                 (ret),
        .output_buffer_valid (output_buffer_valid)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // driver: present a command until accepted; returns at posedge + 1
    task automatic issue(input logic [6:0] c, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        cmd = c; inp0 = a; inp1 = b; cmd_valid = 1'b1;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) check("ready_timeout", 32'(n), 32'd0);
        last_stalls = n;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic read_expect(input logic [6:0] c, input logic [31:0] exp);
        exp_q.push_back(exp);
        issue(c, 32'h0, 32'h0);
    endtask

    task automatic idle(input int n);
        cmd_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n && output_buffer_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", ret, 32'hxxxx_xxxx);
            end else begin
                check("ret", ret, exp_q.pop_front());
            end
        end
    end

    initial begin
        n_checks = 0; n_fail = 0; last_stalls = 0;
        cmd = 7'd0; cmd_valid = 1'b0; inp0 = '0; inp1 = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ret", ret, 32'd0);
        check("reset_obv", 32'(output_buffer_valid), 32'd0);
        check("reset_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // offset 128: (4+128)+(3+128)+(2+128)+(1+128) = 522
        issue(7'd1, 32'h0, 32'd128);
        issue(7'd2, 32'h01020304, 32'h01010101);
        read_expect(7'd3, 32'd522);
        check("read_after_mac_stall", 32'(last_stalls), 32'd1);
        idle(1);
        check("obv_one_cycle", 32'(output_buffer_valid), 32'd0);

        // read-and-clear, then read, then count
        read_expect(7'd4, 32'd522);
        read_expect(7'd3, 32'd0);
        read_expect(7'd5, 32'd1);

        // 4 * (127 * -128) = -65024
        issue(7'd0, 32'h0, 32'h0);
        check("clear_ret", ret, 32'd0);
        issue(7'd1, 32'h0, 32'h0);
        issue(7'd2, 32'h7F7F7F7F, 32'h80808080);
        read_expect(7'd3, 32'hFFFF0200);

        // three back-to-back MACs then an immediate read
        issue(7'd0, 32'h0, 32'h0);
        issue(7'd2, 32'h01010101, 32'h01010101);
        issue(7'd2, 32'h01010101, 32'h01010101);
        issue(7'd2, 32'h01010101, 32'h01010101);
        read_expect(7'd3, 32'd12);
        check("b2b_stall_cycles", 32'(last_stalls), 32'd1);
        read_expect(7'd5, 32'd3);

        // offset -5 (upper inp1 bits ignored): 8*3 + 7*1 + 6*-1 + 5*2 = 35
        issue(7'd0, 32'h0, 32'h0);
        issue(7'd1, 32'h0, 32'hABCDFFFB);
        issue(7'd2, 32'h0A0B0C0D, 32'h02FF0103);
        read_expect(7'd4, 32'd35);

        // clear right after a MAC discards the in-flight product
        issue(7'd0, 32'h0, 32'h0);
        issue(7'd1, 32'h0, 32'h0);
        issue(7'd2, 32'h01010101, 32'h01010101);
        issue(7'd0, 32'h0, 32'h0);
        read_expect(7'd3, 32'd0);
        read_expect(7'd5, 32'd0);

        // undefined opcode zeroes ret, no pulse, state kept
        issue(7'd2, 32'h01010101, 32'h01010101);
        read_expect(7'd3, 32'd4);
        issue(7'd7, 32'h0, 32'h0);
        check("bad_cmd_ret", ret, 32'd0);
        check("bad_cmd_obv", 32'(output_buffer_valid), 32'd0);
        read_expect(7'd3, 32'd4);

        // inputs ignored while cmd_valid is low
        cmd = 7'd2; inp0 = 32'h05050505; inp1 = 32'h05050505; cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        read_expect(7'd5, 32'd1);

        // asynchronous reset with a product in flight
        read_expect(7'd3, 32'd4);
        issue(7'd2, 32'h01010101, 32'h01010101);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_ret", ret, 32'd0);
        check("async_rst_obv", 32'(output_buffer_valid), 32'd0);
        check("async_rst_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        read_expect(7'd3, 32'd0);
        read_expect(7'd5, 32'd0);

        idle(3);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
